// File: rtl/hazard_scoreboard_if.sv
// Purpose : bundles the ID-stage decode fields, the EX branch outcome and the
//           hazard-unit control outputs into one port.
// Ports   : master = pipeline side (drives ID/EX fields, receives controls),
//           slave  = hazard unit (receives ID/EX fields, drives controls).
// Latency/backpressure: none; this is wiring only.
interface hazard_scoreboard_if #(
  parameter int REG_W = 4,
  parameter int SEL_W = 2
);
  // ID-stage instruction description
  logic             id_valid;
  logic [REG_W-1:0] id_src1;
  logic             id_src1_used;
  logic [REG_W-1:0] id_src2;
  logic             id_src2_used;
  logic [REG_W-1:0] id_dst;
  logic             id_wen;
  logic             id_is_load;
  logic             id_is_hlt;
  // EX-stage branch resolution
  logic             ex_br_taken;
  // Control outputs back to the pipeline
  logic             stall;
  logic             bubble;
  logic             flush_ifid;
  logic [SEL_W-1:0] fwd_sel1;
  logic [SEL_W-1:0] fwd_sel2;
  logic             hlt;

  modport master (
    output id_valid, id_src1, id_src1_used, id_src2, id_src2_used,
           id_dst, id_wen, id_is_load, id_is_hlt, ex_br_taken,
    input  stall, bubble, flush_ifid, fwd_sel1, fwd_sel2, hlt
  );

  modport slave (
    input  id_valid, id_src1, id_src1_used, id_src2, id_src2_used,
           id_dst, id_wen, id_is_load, id_is_hlt, ex_br_taken,
    output stall, bubble, flush_ifid, fwd_sel1, fwd_sel2, hlt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Purpose : pipeline hazard unit; shift scoreboard of in-flight writers EX..WB
//           producing forwarding selects, load-use stall/bubble, branch flush
//           and a HLT drain FSM.
// Latency : stall/bubble/flush_ifid combinational from ID/EX inputs;
//           fwd_sel1/2 registered (valid while the instruction is in EX);
//           hlt registered, rises on the edge HLT reaches entry DEPTH-1.
// Backpressure: stall holds PC and IF/ID; bubble inserts a NOP into ID/EX.
// Ports   : clk, rst (sync, active high) plus hz (slave modport) carrying
//           id_* decode fields, ex_br_taken, and stall/bubble/flush_ifid/
//           fwd_sel1/fwd_sel2/hlt.
module hazard_scoreboard #(
  parameter int REG_W    = 4,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 2,
  parameter int SEL_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  hazard_scoreboard_if.slave hz
);

  // One tracked in-flight instruction.
  typedef struct packed {
    logic             vld;
    logic             wen;
    logic             ld;
    logic             hlt;
    logic [REG_W-1:0] dst;
  } entry_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // Entry 0 is EX, entry DEPTH-1 is WB.
  entry_t           sb_q [DEPTH];
  entry_t           sb_d [DEPTH];

  logic [SEL_W-1:0] fwd_sel1_q, fwd_sel1_d;
  logic [SEL_W-1:0] fwd_sel2_q, fwd_sel2_d;

  state_t           state_q;
  logic             hlt_q;

  logic             flush;
  logic             ld_hazard;
  logic             stall;
  logic             accept;
  logic [SEL_W-1:0] sel1_hit;
  logic [SEL_W-1:0] sel2_hit;

  // A source depends on entry e if e is a live writer of that register.
  // R0 is hardwired, and an unread source never creates a dependency.
  function automatic logic src_match(input entry_t e,
                                     input logic [REG_W-1:0] src,
                                     input logic used);
    return e.vld & e.wen & (e.dst == src) & (src != '0) & used;
  endfunction

  // Dependency scan. The WB entry (DEPTH-1) is skipped: the register file
  // writes through, so an ID read in the same cycle already sees the value.
  // Scanning from oldest to youngest lets the youngest producer win.
  always_comb begin
    ld_hazard = 1'b0;
    sel1_hit  = '0;
    sel2_hit  = '0;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      if (src_match(sb_q[k], hz.id_src1, hz.id_src1_used)) begin
        sel1_hit = SEL_W'(k + 1);
        // Load data is not yet available until it reaches entry LOAD_LAT.
        if (sb_q[k].ld && ((k + 1) < LOAD_LAT)) ld_hazard = 1'b1;
      end
      if (src_match(sb_q[k], hz.id_src2, hz.id_src2_used)) begin
        sel2_hit = SEL_W'(k + 1);
        if (sb_q[k].ld && ((k + 1) < LOAD_LAT)) ld_hazard = 1'b1;
      end
    end
  end

  // Control outputs. A taken branch discards the ID instruction, so stalling
  // it would only delay the redirect: flush wins over any stall source.
  // Once HLT is in flight nothing younger may enter.
  always_comb begin
    flush  = hz.ex_br_taken;
    stall  = ~flush & ((state_q != ST_RUN) | (hz.id_valid & ld_hazard));
    accept = hz.id_valid & ~stall & ~flush;
  end

  assign hz.flush_ifid = flush;
  assign hz.stall      = stall;
  assign hz.bubble     = stall | flush;
  assign hz.fwd_sel1   = fwd_sel1_q;
  assign hz.fwd_sel2   = fwd_sel2_q;
  assign hz.hlt        = hlt_q;

  // Next scoreboard contents: shift toward WB, entry 0 takes the accepted
  // ID instruction or an all-zero bubble.
  always_comb begin
    for (int k = 1; k < DEPTH; k++) begin
      sb_d[k] = sb_q[k-1];
    end
    sb_d[0] = '0;
    if (accept) begin
      sb_d[0].vld = 1'b1;
      sb_d[0].wen = hz.id_wen;
      sb_d[0].ld  = hz.id_is_load;
      sb_d[0].hlt = hz.id_is_hlt;
      sb_d[0].dst = hz.id_dst;
    end
  end

  // Forwarding selects travel with the instruction into EX; a bubble in EX
  // must read the plain ID/EX operand value.
  always_comb begin
    fwd_sel1_d = '0;
    fwd_sel2_d = '0;
    if (accept) begin
      fwd_sel1_d = sel1_hit;
      fwd_sel2_d = sel2_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        sb_q[k] <= '0;
      end
      fwd_sel1_q <= '0;
      fwd_sel2_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        sb_q[k] <= sb_d[k];
      end
      fwd_sel1_q <= fwd_sel1_d;
      fwd_sel2_q <= fwd_sel2_d;
    end
  end

  // HLT drain. Entering DRAIN only on an accepted HLT means a HLT flushed by
  // a taken branch is ignored. HALTED is entered on the same edge the HLT
  // entry shifts from DEPTH-2 into the WB slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      hlt_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          hlt_q <= 1'b0;
          if (accept && hz.id_is_hlt) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (sb_q[DEPTH-2].vld && sb_q[DEPTH-2].hlt) begin
            state_q <= ST_HALTED;
            hlt_q   <= 1'b1;
          end
        end
        ST_HALTED: begin
          hlt_q <= 1'b1;
        end
        default: begin
          state_q <= ST_RUN;
          hlt_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_W(4), .SEL_W(2)) if0 ();
  hazard_scoreboard_if #(.REG_W(4), .SEL_W(3)) if1 ();

  hazard_scoreboard #(.REG_W(4), .DEPTH(3), .LOAD_LAT(2), .SEL_W(2)) dut0 (
    .clk(clk), .rst(rst), .hz(if0)
  );
  hazard_scoreboard #(.REG_W(4), .DEPTH(5), .LOAD_LAT(3), .SEL_W(3)) dut1 (
    .clk(clk), .rst(rst), .hz(if1)
  );

  // Reference model: each configuration is a list of in-flight instructions
  // indexed by how many stages past EX they are.
  typedef struct {
    bit v;
    bit w;
    bit ld;
    bit h;
    int dst;
  } ins_t;

  int   dep  [2] = '{3, 5};
  int   llat [2] = '{2, 3};
  ins_t pipe [2][8];
  int   halt_cnt [2];   // edges left until halted, -1 when no HLT in flight
  bit   halted   [2];
  int   esel1    [2];
  int   esel2    [2];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  bit s_valid, s_u1, s_u2, s_wen, s_ld, s_hlt, s_br;
  int s_src1, s_src2, s_dst;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input int a, input bit ua, input int b, input bit ub,
                       input int d, input bit w, input bit ld, input bit h, input bit br);
    s_valid = v; s_src1 = a; s_u1 = ua; s_src2 = b; s_u2 = ub;
    s_dst = d; s_wen = w; s_ld = ld; s_hlt = h; s_br = br;
    if0.id_valid = v; if0.id_src1 = 4'(a); if0.id_src1_used = ua;
    if0.id_src2 = 4'(b); if0.id_src2_used = ub; if0.id_dst = 4'(d);
    if0.id_wen = w; if0.id_is_load = ld; if0.id_is_hlt = h; if0.ex_br_taken = br;
    if1.id_valid = v; if1.id_src1 = 4'(a); if1.id_src1_used = ua;
    if1.id_src2 = 4'(b); if1.id_src2_used = ub; if1.id_dst = 4'(d);
    if1.id_wen = w; if1.id_is_load = ld; if1.id_is_hlt = h; if1.ex_br_taken = br;
  endtask

  task automatic idle_in();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic alu(input int d, input int a, input int b);
    drive(1, a, 1, b, 1, d, 1, 0, 0, 0);
  endtask
  task automatic lw(input int d, input int a);
    drive(1, a, 1, 0, 0, d, 1, 1, 0, 0);
  endtask

  // Producer of register s that is closest to EX and can still forward
  // (anything in the WB slot is served by the register file).
  function automatic int producer(input int c, input int s, input bit used);
    if (!used || s == 0) return -1;
    for (int age = 0; age < dep[c] - 1; age++)
      if (pipe[c][age].v && pipe[c][age].w && pipe[c][age].dst == s) return age;
    return -1;
  endfunction

  // Load data exists only once the load is llat stages past entering EX.
  function automatic bit load_not_ready(input int c);
    for (int age = 0; age < dep[c] - 1; age++) begin
      if (pipe[c][age].v && pipe[c][age].w && pipe[c][age].ld &&
          pipe[c][age].dst != 0 && age + 1 < llat[c] &&
          ((s_u1 && pipe[c][age].dst == s_src1) || (s_u2 && pipe[c][age].dst == s_src2)))
        return 1;
    end
    return 0;
  endfunction

  function automatic bit m_stall(input int c);
    if (s_br) return 0;
    if (halted[c] || halt_cnt[c] >= 0) return 1;
    return s_valid && load_not_ready(c);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 8; i++) pipe[c][i] = '{0, 0, 0, 0, 0};
      halt_cnt[c] = -1; halted[c] = 0; esel1[c] = 0; esel2[c] = 0;
    end
  endtask

  task automatic cmp_all();
    logic [31:0] o_st, o_bu, o_fl, o_s1, o_s2, o_h;
    for (int c = 0; c < 2; c++) begin
      if (c == 0) begin
        o_st = if0.stall; o_bu = if0.bubble; o_fl = if0.flush_ifid;
        o_s1 = if0.fwd_sel1; o_s2 = if0.fwd_sel2; o_h = if0.hlt;
      end else begin
        o_st = if1.stall; o_bu = if1.bubble; o_fl = if1.flush_ifid;
        o_s1 = if1.fwd_sel1; o_s2 = if1.fwd_sel2; o_h = if1.hlt;
      end
      check($sformatf("c%0d_stall", c),  o_st, 32'(m_stall(c)));
      check($sformatf("c%0d_bubble", c), o_bu, 32'(m_stall(c) | s_br));
      check($sformatf("c%0d_flush", c),  o_fl, 32'(s_br));
      check($sformatf("c%0d_sel1", c),   o_s1, 32'(esel1[c]));
      check($sformatf("c%0d_sel2", c),   o_s2, 32'(esel2[c]));
      check($sformatf("c%0d_hlt", c),    o_h,  32'(halted[c]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      for (int c = 0; c < 2; c++) begin
        bit acc;
        int k1, k2;
        acc = s_valid && !m_stall(c) && !s_br;
        k1 = producer(c, s_src1, s_u1);
        k2 = producer(c, s_src2, s_u2);
        esel1[c] = (acc && k1 >= 0) ? k1 + 1 : 0;
        esel2[c] = (acc && k2 >= 0) ? k2 + 1 : 0;
        for (int i = dep[c] - 1; i > 0; i--) pipe[c][i] = pipe[c][i-1];
        if (acc) pipe[c][0] = '{1, s_wen, s_ld, s_hlt, s_dst};
        else     pipe[c][0] = '{0, 0, 0, 0, 0};
        if (halt_cnt[c] > 0) begin
          halt_cnt[c]--;
          if (halt_cnt[c] == 0) begin
            halted[c] = 1; halt_cnt[c] = -1;
          end
        end
        if (acc && s_hlt) halt_cnt[c] = dep[c] - 1;
      end
    end
    #1;
  endtask

  task automatic cyc();
    #1;
    cmp_all();
    tick();
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) begin
      idle_in();
      cyc();
    end
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    idle_in();
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    idle_in(); #1; cmp_all();
    check("rst_stall", if0.stall, 0);
    check("rst_bubble", if0.bubble, 0);
    check("rst_sel1", if0.fwd_sel1, 0);
    check("rst_hlt", if1.hlt, 0);
    tick();

    // 1: forwarding chain, distance 1 and 2
    alu(3, 1, 2); cyc();
    alu(4, 3, 3); cyc();
    check("t1_sel1_d1", if0.fwd_sel1, 1);
    check("t1_sel2_d1", if0.fwd_sel2, 1);
    check("t1_sel1_d1_c1", if1.fwd_sel1, 1);
    idles(5);
    alu(7, 1, 2); cyc();
    alu(8, 1, 2); cyc();
    alu(9, 7, 7); cyc();
    check("t1_sel1_d2", if0.fwd_sel1, 2);
    check("t1_sel2_d2_c1", if1.fwd_sel2, 2);
    idles(5);

    // 2 and 6: load-use, one stall for LOAD_LAT=2 and two for LOAD_LAT=3
    lw(5, 2); cyc();
    alu(6, 5, 1); #1; cmp_all();
    check("t2_stall_c0", if0.stall, 1);
    check("t2_bubble_c0", if0.bubble, 1);
    check("t6_stall1_c1", if1.stall, 1);
    tick();
    alu(6, 5, 1); #1; cmp_all();
    check("t2_nostall_c0", if0.stall, 0);
    check("t6_stall2_c1", if1.stall, 1);
    tick();
    check("t2_sel1_c0", if0.fwd_sel1, 2);
    check("t2_sel2_c0", if0.fwd_sel2, 0);
    alu(6, 5, 1); #1; cmp_all();
    check("t6_nostall_c1", if1.stall, 0);
    tick();
    check("t6_sel1_c1", if1.fwd_sel1, 3);
    check("t6_sel2_c1", if1.fwd_sel2, 0);
    idles(5);

    // 3: R0 never hazards, unused sources never forward
    alu(0, 1, 2); cyc();
    drive(1, 0, 1, 0, 1, 10, 1, 0, 0, 0); #1; cmp_all();
    check("t3_r0_stall", if0.stall, 0);
    tick();
    check("t3_r0_sel1", if0.fwd_sel1, 0);
    check("t3_r0_sel2", if0.fwd_sel2, 0);
    lw(0, 1); cyc();
    drive(1, 0, 1, 0, 1, 10, 1, 0, 0, 0); #1; cmp_all();
    check("t3_r0_ld_stall_c0", if0.stall, 0);
    check("t3_r0_ld_stall_c1", if1.stall, 0);
    tick();
    alu(2, 1, 1); cyc();
    drive(1, 7, 1, 2, 0, 5, 1, 0, 0, 0); cyc();
    check("t3_unused_sel2_c0", if0.fwd_sel2, 0);
    check("t3_unused_sel2_c1", if1.fwd_sel2, 0);
    idles(5);

    // 4: taken branch beats a load-use stall
    lw(5, 1); cyc();
    drive(1, 5, 1, 5, 1, 6, 1, 0, 0, 1); #1; cmp_all();
    check("t4_flush", if0.flush_ifid, 1);
    check("t4_stall_c0", if0.stall, 0);
    check("t4_bubble_c0", if0.bubble, 1);
    check("t4_stall_c1", if1.stall, 0);
    tick();
    check("t4_sel1", if0.fwd_sel1, 0);
    alu(11, 6, 6); cyc();
    check("t4_flushed_no_fwd", if0.fwd_sel1, 0);
    idles(5);

    // 5: halt drain, sticky hlt, reset out of HALTED and mid-drain
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); cyc();       // accepted at edge t
    idle_in(); #1; cmp_all();
    check("t5_stall_c0", if0.stall, 1);
    check("t5_stall_c1", if1.stall, 1);
    tick();                                           // edge t+1
    check("t5_hlt_t1", if0.hlt, 0);
    idle_in(); cyc();                                 // edge t+2
    check("t5_hlt_t2", if0.hlt, 1);
    check("t5_hlt_t2_c1", if1.hlt, 0);
    idles(2);                                         // edges t+3, t+4
    check("t5_hlt_t4_c1", if1.hlt, 1);
    idles(3);
    check("t5_sticky", if0.hlt, 1);
    rst = 1'b1; idle_in(); cyc(); rst = 1'b0;
    check("t5_rst_hlt", if0.hlt, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); cyc();       // HLT at edge t
    rst = 1'b1; idle_in(); cyc(); rst = 1'b0;         // rst at t+1
    idles(4);
    check("t5_middrain_hlt", if0.hlt, 0);
    idle_in(); #1; cmp_all();
    check("t5_middrain_run", if0.stall, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1); cyc();       // HLT flushed in ID
    idle_in(); #1; cmp_all();
    check("t5_flushed_hlt_stall", if0.stall, 0);
    tick();
    idles(4);
    check("t5_flushed_hlt", if0.hlt, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 80) == 0) ||
            ((halted[0] || halted[1]) && $urandom_range(0, 7) == 0);
      drive($urandom_range(0, 7) != 0,
            $urandom_range(0, 3), $urandom_range(0, 3) != 0,
            $urandom_range(0, 3), $urandom_range(0, 3) != 0,
            $urandom_range(0, 3), $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 9) == 0);
      cyc();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
